// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 frame constants and parity helper for the
//                ps2_receiver codebase slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int unsigned c_FRAME_BITS         = 11;
    localparam int unsigned c_BIT_CNT_W          = 4;
    localparam logic [7:0]  c_BREAK_CODE         = 8'hF0;
    localparam logic [7:0]  c_EXT_CODE           = 8'hE0;
    localparam int unsigned c_DEFAULT_FIFO_DEPTH = 8;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scancode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : scancode_fifo
//  Description : Synchronous scan-code FIFO with an extra pointer bit for
//                full/empty disambiguation; head entry shown combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module scancode_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push into a full buffer needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receiver
//  Description : PS/2 keyboard frame receiver feeding a scan-code FIFO.
//                Optional odd-parity checking with PS2_PARITY_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = c_DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RECV   = 2'd1;
    localparam logic [1:0] c_ST_ACCEPT = 2'd2;
    localparam logic [1:0] c_ST_REJECT = 2'd3;

    localparam int                     c_TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT  = c_BIT_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_DATA = c_BIT_CNT_W'(8);

    logic [1:0]             r_clk_sync;
    logic [1:0]             r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_bit;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic [c_TO_W-1:0]      r_idle_cnt;
    logic                   w_timeout;
    logic [8:0]             r_shift;
    logic                   w_parity_ok;
    logic                   w_frame_ok;
    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic                   r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev && !r_clk_sync[1];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = (r_bit_cnt != '0) && !w_fall &&
                       (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // Shift register keeps start + d0..d7; parity and stop are judged separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_shift    <= '0;
        end else if (w_fall) begin
            r_idle_cnt <= '0;
            r_bit_cnt  <= (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
            if (r_bit_cnt <= c_LAST_DATA) r_shift <= {w_bit, r_shift[8:1]};
        end else if (r_bit_cnt == '0) begin
            r_idle_cnt <= '0;
        end else if (w_timeout) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    localparam logic [c_BIT_CNT_W-1:0] c_PARITY_BIT = c_BIT_CNT_W'(9);
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst)                                  r_parity <= 1'b0;
        else if (w_fall && r_bit_cnt == c_PARITY_BIT) r_parity <= w_bit;
    end

    assign w_parity_ok = odd_parity_ok(r_shift[8:1], r_parity);
`else
    assign w_parity_ok = 1'b1;
`endif

    // w_bit is the stop bit when the 11th falling edge is seen.
    assign w_frame_ok = !r_shift[0] && w_bit && w_parity_ok;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RECV: begin
                if (w_fall && r_bit_cnt == c_LAST_BIT)
                    w_state_next = w_frame_ok ? c_ST_ACCEPT : c_ST_REJECT;
                else if (w_timeout)
                    w_state_next = c_ST_IDLE;
            end
            default: w_state_next = w_fall ? c_ST_RECV : c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_push    = (r_state == c_ST_ACCEPT);
        frame_err = (r_state == c_ST_REJECT);
    end

    scancode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (r_shift[8:1]),
        .i_pop   (ready),
        .o_rdata (data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign valid = !w_empty;

    always_ff @(posedge clk) begin
        if (rst)                            r_overflow <= 1'b0;
        else if (w_push && w_full && !ready) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_receiver
//  Description : Self-checking bench for ps2_receiver against a queue-based
//                model of accepted scan codes; honours PS2_PARITY_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int c_DEPTH   = 8;
    localparam int c_TIMEOUT = 100;
    localparam int c_HALF    = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready    = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;

    int         checks    = 0;
    int         errors    = 0;
    int         fe_pulses = 0;
    int         fe_cycles = 0;
    logic       fe_prev   = 1'b0;
    logic [7:0] exp_q[$];
    logic       exp_ovf   = 1'b0;

    ps2_receiver #(
        .FIFO_DEPTH     (c_DEPTH),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
        if (frame_err && !fe_prev) fe_pulses++;
        fe_prev = frame_err;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame layout: bit0 start, bits1..8 data LSB first, bit9 odd parity, bit10 stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                               input bit bad_start, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, bad_start};
    endfunction

    function automatic bit frame_accepted(input logic [10:0] f);
        bit ok;
        ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && ((^f[9:1]) == 1'b1);
`endif
        return ok;
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < c_DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Drives nbits of a frame; pop_at_last raises ready for exactly the push cycle.
    task automatic send_frame(input logic [10:0] f, input int nbits, input bit pop_at_last);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (c_HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_last && i == nbits - 1) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("pre_push_head", data, exp_q[0]);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                repeat (c_HALF - 4) @(negedge clk);
            end else begin
                repeat (c_HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (c_HALF) @(negedge clk);
    endtask

    task automatic send_and_model(input logic [7:0] b, input bit bad_par,
                                  input bit bad_start, input bit bad_stop);
        logic [10:0] f;
        int          fe0;
        bit          acc;
        f   = make_frame(b, bad_par, bad_start, bad_stop);
        acc = frame_accepted(f);
        fe0 = fe_pulses;
        send_frame(f, 11, 1'b0);
        if (acc) model_push(b);
        check("frame_err_count", fe_pulses - fe0, acc ? 0 : 1);
    endtask

    task automatic pop_check(input string tag);
        int waited;
        waited = 0;
        while (!valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, valid, 1);
        check({tag, "_data"}, data, exp_q.pop_front());
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_after"}, valid, exp_q.size() != 0);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_check(tag);
    endtask

    initial begin
        logic [7:0] rb;
        int         kind;
        int         fe_before;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_data", data, 8'h00);
        check("reset_overflow", overflow, 0);
        check("reset_frame_err", frame_err, 0);

        // Good 0x1C frame, then pop.
        send_and_model(8'h1C, 1'b0, 1'b0, 1'b0);
        check("f1c_valid", valid, 1);
        check("f1c_data", data, 8'h1C);
        pop_check("f1c");

        // 0x1C with the parity bit inverted.
        send_and_model(8'h1C, 1'b1, 1'b0, 1'b0);
        check("badpar_valid", valid, exp_q.size() != 0);
        drain("badpar");

        // Nine frames into an eight-deep buffer with no pops.
        for (int i = 1; i <= 9; i++) send_and_model(8'(i), 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_model", overflow, exp_ovf);
        drain("ovf_drain");
        check("ovf_sticky", overflow, 1);

        // Full buffer, push coincides with a pop.
        do_reset();
        for (int i = 0; i < 8; i++) send_and_model(8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        send_frame(make_frame(8'h19, 1'b0, 1'b0, 1'b0), 11, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h19);
        check("full_popush_ovf", overflow, 0);
        drain("full_popush");

        // Partial frame abandoned by timeout, then a break prefix.
        fe_before = fe_pulses;
        send_frame(make_frame(8'h3A, 1'b0, 1'b0, 1'b0), 5, 1'b0);
        repeat (c_TIMEOUT + 1) @(negedge clk);
        send_and_model(8'hF0, 1'b0, 1'b0, 1'b0);
        check("timeout_no_ferr", fe_pulses - fe_before, 0);
        check("timeout_f0_data", data, 8'hF0);
        drain("timeout");

        // Reset in the middle of a frame.
        send_frame(make_frame(8'h55, 1'b0, 1'b0, 1'b0), 6, 1'b0);
        do_reset();
        send_and_model(8'h2D, 1'b0, 1'b0, 1'b0);
        check("midrst_data", data, 8'h2D);
        check("midrst_ovf", overflow, 0);
        drain("midrst");

        // Randomized frames with random corruption and sporadic pops.
        do_reset();
        for (int n = 0; n < 24; n++) begin
            rb   = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            send_and_model(rb, kind == 6, kind == 7, kind == 8);
            if ($urandom_range(0, 3) == 0) drain("rand_all");
            else if ($urandom_range(0, 1) == 0 && exp_q.size() != 0) pop_check("rand_one");
        end
        check("rand_overflow", overflow, exp_ovf);
        drain("rand_final");
        check("ferr_one_cycle", fe_cycles, fe_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
